// File: rtl/ac_sys_check_pkg.sv
// Shared definitions for the system-check sequencer: FSM state encodings,
// fault codes, and a small sizing helper.
package ac_sys_check_pkg;

  // Sequencer states (3-bit encoding, also exported on the debug port)
  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] SETTLE      = 3'd1;
  localparam logic [2:0] WAIT_RESULT = 3'd2;
  localparam logic [2:0] GRANT       = 3'd3;
  localparam logic [2:0] FAULT       = 3'd4;

  // Fault codes reported to the BMC SGPIO path
  localparam logic [1:0] FLT_NONE        = 2'b00;
  localparam logic [1:0] FLT_MISMATCH    = 2'b01;
  localparam logic [1:0] FLT_SKT_REMOVED = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT     = 2'b11;

  // Larger of two integers; sizes the shared settle/timeout counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ac_skt_occ_debounce.sv
// Single-bit debouncer for an active-low socket-occupied strap.
// The output only changes after DEBOUNCE consecutive samples that disagree
// with it; any agreeing sample restarts the count. Resets to 1 (unoccupied).
module ac_skt_occ_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sample_i,
  output logic db_o
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q,  db_d;

  // Count disagreeing samples; toggle and clear when the count reaches DEBOUNCE
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sample_i != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = ~db_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      db_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/ac_sys_check_seq.sv
// System-check sequencer/supervisor. Holds the system-check block in reset
// until AUX has settled, releases it, collects its verdict under a timeout,
// and grants or denies power-up permission. Latches a fault code and re-arms
// on a deep-sleep exit pulse (iREARM, a single-cycle request that is only
// honoured in GRANT or FAULT; AUX loss always takes precedence over it).
// All outputs are registered from the next-state logic so they change on the
// same edge as the state.
module ac_sys_check_seq
  import ac_sys_check_pkg::*;
#(
  parameter int SETTLE_CNT = 20,
  parameter int DEBOUNCE   = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iAUX_PWR_DONE,
  input  logic       iREARM,
  input  logic [1:0] ivCPU_SKT_OCC,
  output logic [1:0] ovCPU_SKT_OCC_DB,
  output logic       oSYS_CHK_RST_N,
  input  logic       iSYS_OK,
  input  logic       iCPU_MISMATCH,
  input  logic       iSOCKET_REMOVED,
  output logic       oPWR_EN,
  output logic       oFAULT,
  output logic [1:0] ovFAULT_CODE,
  output logic       oBUSY,
  output logic [2:0] ovDBG_STATE
);

  // One counter serves both SETTLE and WAIT_RESULT, so size it for the longer
  localparam int CNT_MAX = max_int(SETTLE_CNT, TIMEOUT);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CNT - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          fault_q, fault_d;
  logic [1:0]    code_q,  code_d;
  logic          chk_rst_n_q, chk_rst_n_d;
  logic          pwr_en_q,    pwr_en_d;
  logic          busy_q,      busy_d;

  // Per-bit strap debouncers; they run regardless of sequencer state
  for (genvar g = 0; g < 2; g++) begin : g_db
    ac_skt_occ_debounce #(
      .DEBOUNCE (DEBOUNCE)
    ) u_db (
      .clk_i    (iClk),
      .rst_ni   (iRst_n),
      .sample_i (ivCPU_SKT_OCC[g]),
      .db_o     (ovCPU_SKT_OCC_DB[g])
    );
  end

  // Next-state and fault latch: AUX loss, then re-arm, then per-state rules
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    code_d  = code_q;
    if (!iAUX_PWR_DONE) begin
      // Fault flag and code survive AUX loss for the BMC to read
      state_d = IDLE;
    end else if (iREARM && (state_q == GRANT || state_q == FAULT)) begin
      state_d = SETTLE;
      fault_d = 1'b0;
      code_d  = FLT_NONE;
    end else begin
      case (state_q)
        IDLE: state_d = SETTLE;
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) state_d = WAIT_RESULT;
        end
        WAIT_RESULT: begin
          if (iSOCKET_REMOVED) begin
            state_d = FAULT;
            fault_d = 1'b1;
            code_d  = FLT_SKT_REMOVED;
          end else if (iCPU_MISMATCH) begin
            state_d = FAULT;
            fault_d = 1'b1;
            code_d  = FLT_MISMATCH;
          end else if (iSYS_OK) begin
            state_d = GRANT;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = FAULT;
            fault_d = 1'b1;
            code_d  = FLT_TIMEOUT;
          end
        end
        GRANT: begin
          // GRANT is only entered with iSYS_OK high, so a low level is a fall
          if (iSOCKET_REMOVED) begin
            state_d = FAULT;
            fault_d = 1'b1;
            code_d  = FLT_SKT_REMOVED;
          end else if (!iSYS_OK) begin
            state_d = FAULT;
            fault_d = 1'b1;
            code_d  = iCPU_MISMATCH ? FLT_MISMATCH : FLT_TIMEOUT;
          end
        end
        FAULT: state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Shared counter: cleared on any state change, counts while SETTLE/WAIT hold
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && (state_q == SETTLE || state_q == WAIT_RESULT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Output decode from the next state so outputs track the state register
  always_comb begin
    chk_rst_n_d = (state_d == WAIT_RESULT) || (state_d == GRANT) || (state_d == FAULT);
    pwr_en_d    = (state_d == GRANT);
    busy_d      = (state_d == SETTLE) || (state_d == WAIT_RESULT);
  end

  // State, counter, fault and output registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
      code_q      <= FLT_NONE;
      chk_rst_n_q <= 1'b0;
      pwr_en_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      chk_rst_n_q <= chk_rst_n_d;
      pwr_en_q    <= pwr_en_d;
      busy_q      <= busy_d;
    end
  end

  assign oSYS_CHK_RST_N = chk_rst_n_q;
  assign oPWR_EN        = pwr_en_q;
  assign oFAULT         = fault_q;
  assign ovFAULT_CODE   = code_q;
  assign oBUSY          = busy_q;
  assign ovDBG_STATE    = state_q;

endmodule

// File: tb/tb_ac_sys_check_seq.sv
// Testbench for ac_sys_check_seq: directed scenarios followed by randomized
// stimulus, all checked cycle by cycle against a phase/elapsed-time model.
module tb_ac_sys_check_seq;
  import ac_sys_check_pkg::*;

  localparam int SETTLE_CNT = 20;
  localparam int DEBOUNCE   = 4;
  localparam int TIMEOUT    = 255;
  localparam int W          = 11;

  logic       iClk, iRst_n, iAUX_PWR_DONE, iREARM;
  logic [1:0] ivCPU_SKT_OCC;
  logic       iSYS_OK, iCPU_MISMATCH, iSOCKET_REMOVED;
  logic [1:0] ovCPU_SKT_OCC_DB;
  logic       oSYS_CHK_RST_N, oPWR_EN, oFAULT, oBUSY;
  logic [1:0] ovFAULT_CODE;
  logic [2:0] ovDBG_STATE;

  ac_sys_check_seq #(
    .SETTLE_CNT (SETTLE_CNT),
    .DEBOUNCE   (DEBOUNCE),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .iClk             (iClk),
    .iRst_n           (iRst_n),
    .iAUX_PWR_DONE    (iAUX_PWR_DONE),
    .iREARM           (iREARM),
    .ivCPU_SKT_OCC    (ivCPU_SKT_OCC),
    .ovCPU_SKT_OCC_DB (ovCPU_SKT_OCC_DB),
    .oSYS_CHK_RST_N   (oSYS_CHK_RST_N),
    .iSYS_OK          (iSYS_OK),
    .iCPU_MISMATCH    (iCPU_MISMATCH),
    .iSOCKET_REMOVED  (iSOCKET_REMOVED),
    .oPWR_EN          (oPWR_EN),
    .oFAULT           (oFAULT),
    .ovFAULT_CODE     (ovFAULT_CODE),
    .oBUSY            (oBUSY),
    .ovDBG_STATE      (ovDBG_STATE)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase names and elapsed-cycle counters, derived from the behavioural rules.
  string    m_phase;
  int       m_t;
  bit [1:0] m_db;
  int       m_run[2];
  bit       m_fault;
  bit [1:0] m_code;

  function automatic logic [2:0] phase_code(input string p);
    if (p == "SETTLE") return SETTLE;
    if (p == "WAIT")   return WAIT_RESULT;
    if (p == "GRANT")  return GRANT;
    if (p == "FAULT")  return FAULT;
    return IDLE;
  endfunction

  task automatic model_reset();
    m_phase = "IDLE";
    m_t     = 0;
    m_db    = 2'b11;
    m_run[0] = 0;
    m_run[1] = 0;
    m_fault = 1'b0;
    m_code  = 2'b00;
  endtask

  task automatic model_go_fault(inout string nxt, input bit [1:0] code);
    nxt     = "FAULT";
    m_fault = 1'b1;
    m_code  = code;
  endtask

  // Advance the model by one rising edge using the inputs currently driven
  task automatic model_step();
    string nxt;
    bit rst_n_e, pwr_e, busy_e;
    for (int i = 0; i < 2; i++) begin
      if (ivCPU_SKT_OCC[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == DEBOUNCE) begin
          m_db[i]  = ~m_db[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    nxt = m_phase;
    if (!iAUX_PWR_DONE) begin
      nxt = "IDLE";
    end else if (iREARM && (m_phase == "GRANT" || m_phase == "FAULT")) begin
      nxt = "SETTLE";
      m_fault = 1'b0;
      m_code  = 2'b00;
    end else if (m_phase == "IDLE") begin
      nxt = "SETTLE";
    end else if (m_phase == "SETTLE") begin
      if (m_t + 1 == SETTLE_CNT) nxt = "WAIT";
    end else if (m_phase == "WAIT") begin
      if (iSOCKET_REMOVED)      model_go_fault(nxt, 2'b10);
      else if (iCPU_MISMATCH)   model_go_fault(nxt, 2'b01);
      else if (iSYS_OK)         nxt = "GRANT";
      else if (m_t + 1 == TIMEOUT) model_go_fault(nxt, 2'b11);
    end else if (m_phase == "GRANT") begin
      if (iSOCKET_REMOVED)      model_go_fault(nxt, 2'b10);
      else if (!iSYS_OK)        model_go_fault(nxt, iCPU_MISMATCH ? 2'b01 : 2'b11);
    end
    m_t     = (nxt != m_phase) ? 0 : m_t + 1;
    m_phase = nxt;
    rst_n_e = (m_phase == "WAIT" || m_phase == "GRANT" || m_phase == "FAULT");
    pwr_e   = (m_phase == "GRANT");
    busy_e  = (m_phase == "SETTLE" || m_phase == "WAIT");
    exp_q.push_back({m_db, rst_n_e, pwr_e, m_fault, m_code, busy_e, phase_code(m_phase)});
  endtask

  task automatic compare_outputs();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    chk("skt_db",    ovCPU_SKT_OCC_DB, e[10:9]);
    chk("chk_rst_n", oSYS_CHK_RST_N,   e[8]);
    chk("pwr_en",    oPWR_EN,          e[7]);
    chk("fault",     oFAULT,           e[6]);
    chk("code",      ovFAULT_CODE,     e[5:4]);
    chk("busy",      oBUSY,            e[3]);
    chk("state",     ovDBG_STATE,      e[2:0]);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_db"},    ovCPU_SKT_OCC_DB, 2'b11);
    chk({pfx, "_rst_n"}, oSYS_CHK_RST_N,   1'b0);
    chk({pfx, "_pwr"},   oPWR_EN,          1'b0);
    chk({pfx, "_fault"}, oFAULT,           1'b0);
    chk({pfx, "_code"},  ovFAULT_CODE,     2'b00);
    chk({pfx, "_busy"},  oBUSY,            1'b0);
    chk({pfx, "_state"}, ovDBG_STATE,      IDLE);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge iClk);
    model_step();
    @(negedge iClk);
    compare_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Count cycles the checker reset stays low after the triggering edge
  task automatic measure_low(output int n);
    n = 0;
    cycle();
    iREARM = 1'b0;
    while (oSYS_CHK_RST_N == 1'b0 && n < 200) begin
      n++;
      cycle();
    end
  endtask

  task automatic async_reset_pulse(input string pfx);
    iRst_n = 1'b0;
    #1;
    check_reset_outputs(pfx);
    model_reset();
    #1;
    iRst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [7:0] pat;
    iRst_n          = 1'b0;
    iAUX_PWR_DONE   = 1'b0;
    iREARM          = 1'b0;
    ivCPU_SKT_OCC   = 2'b11;
    iSYS_OK         = 1'b0;
    iCPU_MISMATCH   = 1'b0;
    iSOCKET_REMOVED = 1'b0;
    model_reset();
    repeat (2) @(negedge iClk);
    check_reset_outputs("por");
    iRst_n = 1'b1;
    run(3);

    // Nominal grant
    iAUX_PWR_DONE = 1'b1;
    measure_low(n);
    chk("nom_settle_low", n, SETTLE_CNT);
    run(4);
    iSYS_OK = 1'b1;
    cycle();
    chk("nom_pwr_en", oPWR_EN, 1'b1);
    chk("nom_fault", oFAULT, 1'b0);
    run(5);

    // AUX drop in GRANT, then full settle again on return
    iAUX_PWR_DONE = 1'b0;
    cycle();
    chk("aux_drop_pwr", oPWR_EN, 1'b0);
    chk("aux_drop_rst_n", oSYS_CHK_RST_N, 1'b0);
    chk("aux_drop_state", ovDBG_STATE, IDLE);
    iSYS_OK = 1'b0;
    iAUX_PWR_DONE = 1'b1;
    measure_low(n);
    chk("aux_ret_settle_low", n, SETTLE_CNT);

    // Mismatch and removal in the same WAIT_RESULT cycle
    run(3);
    iCPU_MISMATCH   = 1'b1;
    iSOCKET_REMOVED = 1'b1;
    cycle();
    iCPU_MISMATCH   = 1'b0;
    iSOCKET_REMOVED = 1'b0;
    chk("mm_rm_code", ovFAULT_CODE, FLT_SKT_REMOVED);
    chk("mm_rm_fault", oFAULT, 1'b1);
    chk("mm_rm_pwr", oPWR_EN, 1'b0);
    run(4);

    // Re-arm, then let the verdict time out
    iREARM = 1'b1;
    measure_low(n);
    chk("rearm_settle_low", n, SETTLE_CNT);
    n = 0;
    while (!oFAULT && n < 400) begin
      cycle();
      n++;
    end
    chk("timeout_len", n, TIMEOUT);
    chk("timeout_code", ovFAULT_CODE, FLT_TIMEOUT);

    // Bouncing strap on bit 0: 0,0,0,1,0,0,0,0
    pat = 8'h08;
    for (int i = 0; i < 8; i++) begin
      ivCPU_SKT_OCC[0] = pat[i];
      cycle();
      if (i == 2 || i == 6) chk("bounce_hold", ovCPU_SKT_OCC_DB[0], 1'b1);
    end
    chk("bounce_fall", ovCPU_SKT_OCC_DB[0], 1'b0);

    // Async reset in the middle of SETTLE
    iREARM = 1'b1;
    cycle();
    iREARM = 1'b0;
    run(5);
    chk("pre_rst_busy", oBUSY, 1'b1);
    async_reset_pulse("async");
    run(2);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) iAUX_PWR_DONE = 1'b0;
      else if (!iAUX_PWR_DONE && $urandom_range(0, 7) == 0) iAUX_PWR_DONE = 1'b1;
      iREARM          = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) iSYS_OK = ~iSYS_OK;
      iCPU_MISMATCH   = ($urandom_range(0, 99) == 0);
      iSOCKET_REMOVED = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 5) == 0) ivCPU_SKT_OCC = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 999) == 0) async_reset_pulse("rnd_rst");
      cycle();
    end
    iREARM = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
